// File: rtl/sec60_counter.sv
// Seconds counter 00..59 in packed BCD with start/pause/clear buttons.
// Prescaler derives the count step from clk; each raw button passes through a
// 2-flop synchroniser and a consecutive-cycle debouncer before reaching the FSM.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | cleared: minute=00, prescaler held at 0
// S_RUN   | prescaler advancing, minute steps on every tick
// S_PAUSE | prescaler and minute frozen; resume finishes the partial second
module sec60_counter #(
  parameter int TICK_DIV  = 50_000_000,
  parameter int DB_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_start,
  input  logic       btn_clr,
  output logic [7:0] minute,
  output logic       carry,
  output logic       running
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DW = $clog2(DB_CYCLES + 1);
  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DB_LAST   = DW'(DB_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE} state_t;

  // Button index 0 = start, 1 = clear.
  logic [1:0]    btn_raw;
  logic [1:0]    sync1_q, sync1_d;
  logic [1:0]    sync2_q, sync2_d;
  logic [1:0]    db_q, db_d;
  logic [1:0]    press_q, press_d;
  logic [DW-1:0] db_cnt_q [2];
  logic [DW-1:0] db_cnt_d [2];

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [7:0]    minute_q, minute_d;
  logic          carry_q, carry_d;
  logic          running_q, running_d;
  logic          start_p, clr_p, tick;

  assign btn_raw = {btn_clr, btn_start};
  assign start_p = press_q[0];
  assign clr_p   = press_q[1];

  // Synchronise, debounce and edge-detect both buttons.
  always_comb begin
    sync1_d     = btn_raw;
    sync2_d     = sync1_q;
    db_d        = db_q;
    db_cnt_d[0] = '0;
    db_cnt_d[1] = '0;
    for (int i = 0; i < 2; i++) begin
      if (sync2_q[i] != db_q[i]) begin
        // The level is accepted on the cycle the disagreement run hits DB_CYCLES.
        if (db_cnt_q[i] == DB_LAST) db_d[i] = ~db_q[i];
        else                        db_cnt_d[i] = db_cnt_q[i] + DW'(1);
      end
    end
    // Pulse registered on the same edge db rises, so the FSM sees it one edge later.
    press_d = db_d & ~db_q;
  end

  // Run-control next-state: clear always wins over start.
  always_comb begin
    state_d = state_q;
    if (clr_p) begin
      state_d = S_IDLE;
    end else if (start_p) begin
      case (state_q)
        S_IDLE:  state_d = S_RUN;
        S_RUN:   state_d = S_PAUSE;
        S_PAUSE: state_d = S_RUN;
        default: state_d = S_IDLE;
      endcase
    end
    running_d = (state_d == S_RUN);
  end

  // Prescaler and BCD count.
  always_comb begin
    tick     = (state_q == S_RUN) && (presc_q == TICK_LAST);
    presc_d  = presc_q;
    minute_d = minute_q;
    carry_d  = 1'b0;
    if (state_q == S_RUN) presc_d = tick ? '0 : presc_q + PW'(1);
    if (tick) begin
      if ((minute_q[3:0] > 4'd9) || (minute_q[7:4] > 4'd5)) begin
        minute_d = 8'h00;
      end else if (minute_q == 8'h59) begin
        minute_d = 8'h00;
        carry_d  = 1'b1;
      end else if (minute_q[3:0] < 4'd9) begin
        minute_d = minute_q + 8'd1;
      end else begin
        minute_d = {minute_q[7:4] + 4'd1, 4'd0};
      end
    end
    // Clearing (or sitting in IDLE) forces the datapath back to zero.
    if (state_d == S_IDLE) begin
      presc_d  = '0;
      minute_d = 8'h00;
      carry_d  = 1'b0;
    end
  end

  // Register all state; reset is immediate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      db_q      <= '0;
      press_q   <= '0;
      for (int i = 0; i < 2; i++) db_cnt_q[i] <= '0;
      state_q   <= S_IDLE;
      presc_q   <= '0;
      minute_q  <= 8'h00;
      carry_q   <= 1'b0;
      running_q <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      db_q      <= db_d;
      press_q   <= press_d;
      for (int i = 0; i < 2; i++) db_cnt_q[i] <= db_cnt_d[i];
      state_q   <= state_d;
      presc_q   <= presc_d;
      minute_q  <= minute_d;
      carry_q   <= carry_d;
      running_q <= running_d;
    end
  end

  assign minute  = minute_q;
  assign carry   = carry_q;
  assign running = running_q;

endmodule

// File: tb/tb_sec60_counter.sv
// Directed bench for sec60_counter with TICK_DIV=4, DB_CYCLES=3.
module tb_sec60_counter;

  logic       clk;
  logic       rst_n;
  logic       btn_start;
  logic       btn_clr;
  logic [7:0] minute;
  logic       carry;
  logic       running;

  int n_checks = 0;
  int n_fail   = 0;

  sec60_counter #(.TICK_DIV(4), .DB_CYCLES(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_start (btn_start),
    .btn_clr   (btn_clr),
    .minute    (minute),
    .carry     (carry),
    .running   (running)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance n rising edges, landing on the following falling edge.
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_minute(input logic [7:0] target, input int budget, input string name);
    int k;
    k = 0;
    while (minute !== target && k < budget) begin
      step(1);
      k++;
    end
    n_checks++;
    if (minute !== target) begin
      $display("FAIL %s timeout minute=%h required=%h", name, minute, target);
      n_fail++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (minute !== 8'h00) begin $display("FAIL reset_minute actual=%h required=00", minute); n_fail++; end
    n_checks++; if (carry !== 1'b0) begin $display("FAIL reset_carry actual=%b required=0", carry); n_fail++; end
    n_checks++; if (running !== 1'b0) begin $display("FAIL reset_running actual=%b required=0", running); n_fail++; end
    step(3);
    rst_n = 1'b1;
    step(2);
    n_checks++; if (minute !== 8'h00 || running !== 1'b0) begin $display("FAIL reset_release minute=%h running=%b required 00/0", minute, running); n_fail++; end
  endtask

  task automatic test_start;
    btn_start = 1'b1;
    step(5);
    n_checks++; if (running !== 1'b0) begin $display("FAIL start_early running=%b required=0", running); n_fail++; end
    step(1);
    n_checks++; if (running !== 1'b1) begin $display("FAIL start_edge6 running=%b required=1", running); n_fail++; end
    n_checks++; if (minute !== 8'h00) begin $display("FAIL start_minute0 actual=%h required=00", minute); n_fail++; end
    step(3);
    n_checks++; if (minute !== 8'h00) begin $display("FAIL start_edge9 minute=%h required=00", minute); n_fail++; end
    step(1);
    n_checks++; if (minute !== 8'h01) begin $display("FAIL start_first_inc minute=%h required=01", minute); n_fail++; end
    btn_start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      n_checks++; if (running !== 1'b1) begin $display("FAIL start_single_toggle cyc=%0d running=%b required=1", i, running); n_fail++; end
    end
  endtask

  task automatic test_wrap;
    logic [7:0] prev, exp;
    wait_minute(8'h07, 100, "wrap_reach07");
    prev = 8'h07;
    for (int n = 8; n <= 60; n++) begin
      exp = (n == 60) ? 8'h00 : 8'(((n / 10) << 4) | (n % 10));
      for (int s = 1; s <= 4; s++) begin
        step(1);
        if (s < 4) begin
          n_checks++; if (minute !== prev) begin $display("FAIL wrap_hold n=%0d minute=%h required=%h", n, minute, prev); n_fail++; end
          n_checks++; if (carry !== 1'b0) begin $display("FAIL wrap_carry_idle n=%0d carry=%b required=0", n, carry); n_fail++; end
        end else begin
          n_checks++; if (minute !== exp) begin $display("FAIL wrap_step n=%0d minute=%h required=%h", n, minute, exp); n_fail++; end
          n_checks++; if (carry !== (n == 60)) begin $display("FAIL wrap_carry n=%0d carry=%b required=%b", n, carry, (n == 60)); n_fail++; end
        end
      end
      prev = exp;
    end
    step(1);
    n_checks++; if (carry !== 1'b0) begin $display("FAIL wrap_carry_one_cycle carry=%b required=0", carry); n_fail++; end
  endtask

  task automatic test_pause_resume;
    wait_minute(8'h22, 200, "pause_reach22");
    btn_start = 1'b1;
    step(5);
    n_checks++; if (running !== 1'b1 || minute !== 8'h23) begin $display("FAIL pause_before running=%b minute=%h required 1/23", running, minute); n_fail++; end
    step(1);
    n_checks++; if (running !== 1'b0) begin $display("FAIL pause_running actual=%b required=0", running); n_fail++; end
    for (int i = 0; i < 40; i++) begin
      step(1);
      if (i == 3) btn_start = 1'b0;
      n_checks++; if (minute !== 8'h23 || running !== 1'b0) begin $display("FAIL pause_hold cyc=%0d minute=%h running=%b required 23/0", i, minute, running); n_fail++; end
    end
    btn_start = 1'b1;
    step(5);
    n_checks++; if (running !== 1'b0) begin $display("FAIL resume_early running=%b required=0", running); n_fail++; end
    step(1);
    n_checks++; if (running !== 1'b1) begin $display("FAIL resume_running actual=%b required=1", running); n_fail++; end
    step(1);
    n_checks++; if (minute !== 8'h23) begin $display("FAIL resume_partial minute=%h required=23", minute); n_fail++; end
    step(1);
    n_checks++; if (minute !== 8'h24) begin $display("FAIL resume_inc minute=%h required=24", minute); n_fail++; end
    step(2);
    btn_start = 1'b0;
  endtask

  task automatic test_clr_start;
    btn_start = 1'b1;
    btn_clr   = 1'b1;
    step(6);
    n_checks++; if (running !== 1'b0) begin $display("FAIL clr_running actual=%b required=0", running); n_fail++; end
    n_checks++; if (minute !== 8'h00) begin $display("FAIL clr_minute actual=%h required=00", minute); n_fail++; end
    n_checks++; if (carry !== 1'b0) begin $display("FAIL clr_carry actual=%b required=0", carry); n_fail++; end
    step(4);
    btn_start = 1'b0;
    btn_clr   = 1'b0;
    step(12);
    n_checks++; if (running !== 1'b0 || minute !== 8'h00) begin $display("FAIL clr_stays_idle running=%b minute=%h required 0/00", running, minute); n_fail++; end
  endtask

  task automatic test_glitch;
    btn_start = 1'b1;
    step(2);
    btn_start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step(1);
      n_checks++; if (running !== 1'b0) begin $display("FAIL glitch_ignored cyc=%0d running=%b required=0", i, running); n_fail++; end
    end
    // Bounce burst, no high run longer than 2 cycles.
    btn_start = 1'b1; step(2);
    btn_start = 1'b0; step(1);
    btn_start = 1'b1; step(1);
    btn_start = 1'b0; step(2);
    btn_start = 1'b1; step(2);
    btn_start = 1'b0; step(1);
    n_checks++; if (running !== 1'b0) begin $display("FAIL bounce_ignored running=%b required=0", running); n_fail++; end
    btn_start = 1'b1;
    step(5);
    n_checks++; if (running !== 1'b0) begin $display("FAIL bounce_clean_early running=%b required=0", running); n_fail++; end
    step(1);
    n_checks++; if (running !== 1'b1) begin $display("FAIL bounce_clean_press running=%b required=1", running); n_fail++; end
    step(4);
    btn_start = 1'b0;
    step(15);
    n_checks++; if (running !== 1'b1) begin $display("FAIL bounce_one_toggle running=%b required=1", running); n_fail++; end
  endtask

  task automatic test_async_reset;
    wait_minute(8'h47, 400, "areset_reach47");
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (minute !== 8'h00) begin $display("FAIL areset_minute actual=%h required=00", minute); n_fail++; end
    n_checks++; if (running !== 1'b0) begin $display("FAIL areset_running actual=%b required=0", running); n_fail++; end
    n_checks++; if (carry !== 1'b0) begin $display("FAIL areset_carry actual=%b required=0", carry); n_fail++; end
    step(3);
    rst_n = 1'b1;
    step(10);
    n_checks++; if (minute !== 8'h00 || running !== 1'b0) begin $display("FAIL areset_after minute=%h running=%b required 00/0", minute, running); n_fail++; end
  endtask

  initial begin
    btn_start = 1'b0;
    btn_clr   = 1'b0;
    rst_n     = 1'b1;
    test_reset;
    test_start;
    test_wrap;
    test_pause_resume;
    test_clr_start;
    test_glitch;
    test_async_reset;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
